// File: rtl/mem_stage.sv
// Memory stage: drives the single-outstanding data bus for loads/stores, aligns store
// lanes, extracts/extends load data, and registers the result toward writeback.
module mem_stage #(
    parameter int   TAG_WIDTH       = 4,
    parameter logic MISALIGN_EXC_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_M,
    input  logic                 ready_wb,
    output logic                 ready_mem,
    input  logic [31:0]          pc_mem,
    input  logic                 lsu_en_mem,
    input  logic                 lsu_op_mem,
    input  logic [2:0]           lsu_dtype_mem,
    input  logic [31:0]          lsu_addr_mem,
    input  logic [31:0]          lsu_wdata_mem,
    input  logic                 rd_wr_en_mem,
    input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
    input  logic [4:0]           rd_wr_addr_mem,
    input  logic [31:0]          rd_wr_data_mem,
    input  logic                 exc_taken_mem,
    output logic                 data_req,
    output logic [31:0]          data_addr,
    output logic                 data_we,
    output logic [3:0]           data_be,
    output logic [31:0]          data_wdata,
    input  logic                 data_gnt,
    input  logic                 data_rvalid,
    input  logic [31:0]          data_rdata,
    input  logic                 data_err,
    output logic [31:0]          pc_wb,
    output logic                 rd_wr_en_wb,
    output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
    output logic [4:0]           rd_wr_addr_wb,
    output logic [31:0]          rd_wr_data_wb,
    output logic                 exc_taken_wb,
    output logic                 lsu_misalign_wb,
    output logic                 lsu_err_wb,
    output logic                 forward_mem_en,
    output logic [TAG_WIDTH-1:0] forward_mem_tag,
    output logic [4:0]           forward_mem_addr,
    output logic [31:0]          forward_mem_wdata
);

    // state       | meaning
    // IDLE        | no bus transaction; non-LSU / faulting ops pass in one cycle
    // WAIT_GNT    | request issued, held stable until granted
    // WAIT_RVALID | granted, waiting for the response
    // DONE        | response captured, waiting for writeback to accept

    localparam logic       LSU_OP_LD = 1'b0;
    localparam logic       LSU_OP_ST = 1'b1;
    localparam logic [2:0] DT_BYTE   = 3'b000;
    localparam logic [2:0] DT_HALF   = 3'b001;
    localparam logic [2:0] DT_WORD   = 3'b010;
    localparam logic [2:0] DT_UBYTE  = 3'b100;
    localparam logic [2:0] DT_UHALF  = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, DONE} state_e;

    state_e      r_state, w_state_nxt;
    logic        r_kill;
    logic [31:0] r_ld_data;
    logic        r_err;

    logic        w_is_half, w_is_word, w_aligned, w_misalign, w_act;
    logic        w_is_load, w_is_store, w_retire, w_bus_err, w_squash, w_exc;
    logic        w_fwd_valid;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_ext, w_ld_final;

    assign w_is_half  = (lsu_dtype_mem == DT_HALF) || (lsu_dtype_mem == DT_UHALF);
    assign w_is_word  = (lsu_dtype_mem == DT_WORD);
    assign w_aligned  = w_is_word ? (lsu_addr_mem[1:0] == 2'b00) :
                        w_is_half ? ~lsu_addr_mem[0] : 1'b1;
    assign w_misalign = MISALIGN_EXC_EN & lsu_en_mem & ~exc_taken_mem & ~w_aligned;
    assign w_act      = lsu_en_mem & ~exc_taken_mem & ~flush_M & (w_aligned | ~MISALIGN_EXC_EN);
    assign w_is_load  = lsu_en_mem & (lsu_op_mem == LSU_OP_LD);
    assign w_is_store = lsu_en_mem & (lsu_op_mem == LSU_OP_ST);

    assign data_addr  = {lsu_addr_mem[31:2], 2'b00};
    assign data_we    = (lsu_op_mem == LSU_OP_ST);

    always_comb begin
        data_wdata = lsu_wdata_mem;
        data_be    = 4'b1111;
        case (lsu_dtype_mem)
            DT_BYTE, DT_UBYTE: begin
                data_wdata = {4{lsu_wdata_mem[7:0]}};
                data_be    = 4'b0001 << lsu_addr_mem[1:0];
            end
            DT_HALF, DT_UHALF: begin
                data_wdata = {2{lsu_wdata_mem[15:0]}};
                data_be    = 4'b0011 << {lsu_addr_mem[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign w_byte = data_rdata[{lsu_addr_mem[1:0], 3'b000} +: 8];
    assign w_half = data_rdata[{lsu_addr_mem[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_ext = data_rdata;
        case (lsu_dtype_mem)
            DT_BYTE:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            DT_UBYTE: w_ld_ext = {24'h0, w_byte};
            DT_HALF:  w_ld_ext = {{16{w_half[15]}}, w_half};
            DT_UHALF: w_ld_ext = {16'h0, w_half};
            default:  ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        data_req    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                data_req = w_act;
                if (w_act) w_state_nxt = data_gnt ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_GNT: begin
                data_req = 1'b1;
                if (data_gnt) w_state_nxt = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (data_rvalid) begin
                    w_retire    = ready_wb;
                    w_state_nxt = ready_wb ? IDLE : DONE;
                end
            end
            DONE: begin
                if (ready_wb) begin
                    w_retire    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ready_mem  = (r_state == IDLE && !w_act) ? ready_wb : w_retire;
    assign w_ld_final = (r_state == DONE) ? r_ld_data : w_ld_ext;
    assign w_bus_err  = (r_state == DONE) ? r_err :
                        ((r_state == WAIT_RVALID) & data_rvalid & data_err);
    assign w_squash   = flush_M | r_kill;
    assign w_exc      = exc_taken_mem | w_misalign | w_bus_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_kill    <= 1'b0;
            r_ld_data <= 32'h0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // A flush after issue cannot retract the request; remember to squash the result.
            if (w_retire)
                r_kill <= 1'b0;
            else if (flush_M && r_state != IDLE)
                r_kill <= 1'b1;
            if (r_state == WAIT_RVALID && data_rvalid && !ready_wb) begin
                r_ld_data <= w_ld_ext;
                r_err     <= data_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_wb           <= 32'h0;
            rd_wr_en_wb     <= 1'b0;
            rd_wr_tag_wb    <= '0;
            rd_wr_addr_wb   <= 5'h0;
            rd_wr_data_wb   <= 32'h0;
            exc_taken_wb    <= 1'b0;
            lsu_misalign_wb <= 1'b0;
            lsu_err_wb      <= 1'b0;
        end else if (ready_mem) begin
            pc_wb           <= pc_mem;
            rd_wr_en_wb     <= rd_wr_en_mem & ~w_is_store & ~w_squash & ~w_exc;
            rd_wr_tag_wb    <= rd_wr_tag_mem;
            rd_wr_addr_wb   <= rd_wr_addr_mem;
            rd_wr_data_wb   <= w_is_load ? w_ld_final : rd_wr_data_mem;
            exc_taken_wb    <= w_exc & ~w_squash;
            lsu_misalign_wb <= w_misalign & ~w_squash;
            lsu_err_wb      <= w_bus_err & ~w_squash;
        end else if (ready_wb) begin
            // WB consumed its entry while MEM is still busy: hand it a bubble.
            rd_wr_en_wb     <= 1'b0;
            exc_taken_wb    <= 1'b0;
            lsu_misalign_wb <= 1'b0;
            lsu_err_wb      <= 1'b0;
        end
    end

    assign w_fwd_valid = ((r_state == IDLE) & ~lsu_en_mem) |
                         (w_is_load & (((r_state == WAIT_RVALID) & data_rvalid) | (r_state == DONE)));

    assign forward_mem_en    = w_fwd_valid & rd_wr_en_mem & ~flush_M & ~r_kill & ~w_exc;
    assign forward_mem_tag   = rd_wr_tag_mem;
    assign forward_mem_addr  = rd_wr_addr_mem;
    assign forward_mem_wdata = w_is_load ? w_ld_final : rd_wr_data_mem;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores over a simple bus,
// misalignment, flush-kill, writeback backpressure and mid-transaction reset.
module tb_mem_stage;

    localparam int TW = 4;

    logic          clk, reset, flush_M, ready_wb, ready_mem;
    logic [31:0]   pc_mem;
    logic          lsu_en_mem, lsu_op_mem;
    logic [2:0]    lsu_dtype_mem;
    logic [31:0]   lsu_addr_mem, lsu_wdata_mem;
    logic          rd_wr_en_mem;
    logic [TW-1:0] rd_wr_tag_mem;
    logic [4:0]    rd_wr_addr_mem;
    logic [31:0]   rd_wr_data_mem;
    logic          exc_taken_mem;
    logic          data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [31:0]   data_addr, data_wdata, data_rdata;
    logic [3:0]    data_be;
    logic [31:0]   pc_wb, rd_wr_data_wb, forward_mem_wdata;
    logic          rd_wr_en_wb, exc_taken_wb, lsu_misalign_wb, lsu_err_wb, forward_mem_en;
    logic [TW-1:0] rd_wr_tag_wb, forward_mem_tag;
    logic [4:0]    rd_wr_addr_wb, forward_mem_addr;

    int n_chk = 0;
    int n_fail = 0;

    mem_stage #(.TAG_WIDTH(TW), .MISALIGN_EXC_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush_M(flush_M), .ready_wb(ready_wb), .ready_mem(ready_mem),
        .pc_mem(pc_mem), .lsu_en_mem(lsu_en_mem), .lsu_op_mem(lsu_op_mem),
        .lsu_dtype_mem(lsu_dtype_mem), .lsu_addr_mem(lsu_addr_mem), .lsu_wdata_mem(lsu_wdata_mem),
        .rd_wr_en_mem(rd_wr_en_mem), .rd_wr_tag_mem(rd_wr_tag_mem), .rd_wr_addr_mem(rd_wr_addr_mem),
        .rd_wr_data_mem(rd_wr_data_mem), .exc_taken_mem(exc_taken_mem),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .pc_wb(pc_wb), .rd_wr_en_wb(rd_wr_en_wb), .rd_wr_tag_wb(rd_wr_tag_wb),
        .rd_wr_addr_wb(rd_wr_addr_wb), .rd_wr_data_wb(rd_wr_data_wb), .exc_taken_wb(exc_taken_wb),
        .lsu_misalign_wb(lsu_misalign_wb), .lsu_err_wb(lsu_err_wb),
        .forward_mem_en(forward_mem_en), .forward_mem_tag(forward_mem_tag),
        .forward_mem_addr(forward_mem_addr), .forward_mem_wdata(forward_mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        flush_M = 0; ready_wb = 1; pc_mem = 0; lsu_en_mem = 0; lsu_op_mem = 0;
        lsu_dtype_mem = 0; lsu_addr_mem = 0; lsu_wdata_mem = 0; rd_wr_en_mem = 0;
        rd_wr_tag_mem = 0; rd_wr_addr_mem = 0; rd_wr_data_mem = 0; exc_taken_mem = 0;
        data_gnt = 0; data_rvalid = 0; data_rdata = 0; data_err = 0;
    endtask

    task automatic set_lsu(input logic op, input logic [2:0] dt, input logic [31:0] addr,
                           input logic [31:0] wd, input logic rd_en, input logic [4:0] rd);
        lsu_en_mem = 1; lsu_op_mem = op; lsu_dtype_mem = dt; lsu_addr_mem = addr;
        lsu_wdata_mem = wd; rd_wr_en_mem = rd_en; rd_wr_addr_mem = rd;
    endtask

    // Zero-wait load: gnt with the request, rvalid the following cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] dt,
                           input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk);
        set_idle();
        set_lsu(1'b0, dt, addr, 32'h0, 1'b1, 5'd7);
        data_gnt = 1;
        #1;
        chk({tag, "_req"}, data_req, 1);
        chk({tag, "_addr"}, data_addr, {addr[31:2], 2'b00});
        chk({tag, "_rdy_req"}, ready_mem, 0);
        @(negedge clk);
        data_gnt = 0; data_rvalid = 1; data_rdata = rdata;
        #1;
        chk({tag, "_rdy_rv"}, ready_mem, 1);
        chk({tag, "_fwd_en"}, forward_mem_en, 1);
        chk({tag, "_fwd_data"}, forward_mem_wdata, exp);
        @(posedge clk); #1;
        chk({tag, "_wb_en"}, rd_wr_en_wb, 1);
        chk({tag, "_wb_data"}, rd_wr_data_wb, exp);
    endtask

    initial begin
        set_idle();
        reset = 1;
        #2;
        chk("rst_req", data_req, 0);
        chk("rst_rdy", ready_mem, 1);
        chk("rst_fwd", forward_mem_en, 0);
        chk("rst_wb_en", rd_wr_en_wb, 0);
        chk("rst_exc", exc_taken_wb, 0);
        @(negedge clk);
        reset = 0;

        // ALU op
        @(negedge clk);
        rd_wr_en_mem = 1; rd_wr_addr_mem = 5; rd_wr_data_mem = 32'h1234; rd_wr_tag_mem = 3; pc_mem = 32'h100;
        #1;
        chk("alu_rdy", ready_mem, 1);
        chk("alu_req", data_req, 0);
        chk("alu_fwd_en", forward_mem_en, 1);
        chk("alu_fwd_data", forward_mem_wdata, 32'h1234);
        @(posedge clk); #1;
        chk("alu_wb_en", rd_wr_en_wb, 1);
        chk("alu_wb_addr", rd_wr_addr_wb, 5);
        chk("alu_wb_data", rd_wr_data_wb, 32'h1234);
        chk("alu_wb_tag", rd_wr_tag_wb, 3);
        chk("alu_wb_pc", pc_wb, 32'h100);

        do_load("lb",  32'h1003, 3'b000, 32'h80FF_FF7F, 32'hFFFF_FF80);
        do_load("lbu", 32'h1003, 3'b100, 32'h80FF_FF7F, 32'h0000_0080);
        do_load("lh",  32'h1802, 3'b001, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu", 32'h1800, 3'b101, 32'h8001_9234, 32'h0000_9234);

        // SH with grant withheld for three cycles
        @(negedge clk);
        set_idle();
        set_lsu(1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 1'b0, 5'd0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) data_gnt = 1;
            #1;
            chk($sformatf("sh_req%0d", c), data_req, 1);
            chk($sformatf("sh_addr%0d", c), data_addr, 32'h2000);
            chk($sformatf("sh_be%0d", c), data_be, 4'b1100);
            chk($sformatf("sh_wdata%0d", c), data_wdata, 32'hABCD_ABCD);
            chk($sformatf("sh_we%0d", c), data_we, 1);
            chk($sformatf("sh_rdy%0d", c), ready_mem, 0);
            @(negedge clk);
        end
        data_gnt = 0; data_rvalid = 1;
        #1;
        chk("sh_rdy_rv", ready_mem, 1);
        chk("sh_req_rv", data_req, 0);
        @(posedge clk); #1;
        chk("sh_wb_en", rd_wr_en_wb, 0);
        chk("sh_wb_exc", exc_taken_wb, 0);

        // SB lane check
        @(negedge clk);
        set_idle();
        set_lsu(1'b1, 3'b000, 32'h7001, 32'h1234_5655, 1'b0, 5'd0);
        data_gnt = 1;
        #1;
        chk("sb_be", data_be, 4'b0010);
        chk("sb_wdata", data_wdata, 32'h5555_5555);
        @(negedge clk);
        data_gnt = 0; data_rvalid = 1;
        #1;
        chk("sb_rdy_rv", ready_mem, 1);

        // Misaligned LW
        @(negedge clk);
        set_idle();
        set_lsu(1'b0, 3'b010, 32'h3001, 32'h0, 1'b1, 5'd9);
        #1;
        chk("mis_req", data_req, 0);
        chk("mis_rdy", ready_mem, 1);
        chk("mis_fwd", forward_mem_en, 0);
        @(posedge clk); #1;
        chk("mis_wb_exc", exc_taken_wb, 1);
        chk("mis_wb_mis", lsu_misalign_wb, 1);
        chk("mis_wb_en", rd_wr_en_wb, 0);
        chk("mis_wb_err", lsu_err_wb, 0);

        // LW flushed while waiting for rvalid, then bus error
        @(negedge clk);
        set_idle();
        set_lsu(1'b0, 3'b010, 32'h4000, 32'h0, 1'b1, 5'd10);
        data_gnt = 1;
        #1;
        chk("kill_req", data_req, 1);
        @(negedge clk);
        data_gnt = 0; flush_M = 1;
        #1;
        chk("kill_rdy_wait", ready_mem, 0);
        @(negedge clk);
        flush_M = 0; data_rvalid = 1; data_err = 1; data_rdata = 32'h1111_1111;
        #1;
        chk("kill_rdy_rv", ready_mem, 1);
        chk("kill_fwd", forward_mem_en, 0);
        @(posedge clk); #1;
        chk("kill_wb_en", rd_wr_en_wb, 0);
        chk("kill_wb_exc", exc_taken_wb, 0);
        chk("kill_wb_err", lsu_err_wb, 0);

        // LW with writeback stalled for two cycles after rvalid
        @(negedge clk);
        set_idle();
        set_lsu(1'b0, 3'b010, 32'h5000, 32'h0, 1'b1, 5'd11);
        pc_mem = 32'h500; data_gnt = 1;
        @(negedge clk);
        data_gnt = 0; data_rvalid = 1; data_rdata = 32'hDEAD_BEEF; ready_wb = 0;
        #1;
        chk("bp_rdy_rv", ready_mem, 0);
        chk("bp_fwd_rv", forward_mem_en, 1);
        chk("bp_fwd_data_rv", forward_mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        data_rvalid = 0; data_rdata = 32'h0;
        #1;
        chk("bp_done_rdy", ready_mem, 0);
        chk("bp_done_fwd", forward_mem_en, 1);
        chk("bp_done_fwd_data", forward_mem_wdata, 32'hDEAD_BEEF);
        chk("bp_done_req", data_req, 0);
        chk("bp_wb_hold", rd_wr_data_wb, 32'h1111_1111);
        @(negedge clk);
        ready_wb = 1;
        #1;
        chk("bp_rdy_ret", ready_mem, 1);
        @(posedge clk); #1;
        chk("bp_wb_en", rd_wr_en_wb, 1);
        chk("bp_wb_data", rd_wr_data_wb, 32'hDEAD_BEEF);
        chk("bp_wb_pc", pc_wb, 32'h500);

        // SW stuck in WAIT_GNT, then reset mid-transaction
        @(negedge clk);
        set_idle();
        set_lsu(1'b1, 3'b010, 32'h6000, 32'hCAFE_F00D, 1'b0, 5'd0);
        ready_wb = 0;
        @(negedge clk);
        #1;
        chk("rw_req", data_req, 1);
        chk("rw_wb_hold", rd_wr_en_wb, 1);
        #1;
        reset = 1;
        set_idle();
        #1;
        chk("rw_req_rst", data_req, 0);
        chk("rw_rdy_rst", ready_mem, 1);
        chk("rw_wb_en_rst", rd_wr_en_wb, 0);
        chk("rw_pc_rst", pc_wb, 0);
        chk("rw_data_rst", rd_wr_data_wb, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        rd_wr_en_mem = 1; rd_wr_addr_mem = 3; rd_wr_data_mem = 32'h77;
        #1;
        chk("post_rst_rdy", ready_mem, 1);
        @(posedge clk); #1;
        chk("post_rst_wb_data", rd_wr_data_wb, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
